div_repsub: RTL and testbench
=============================

# div_repsub

Sequential unsigned divider that computes quotient and remainder by repeated subtraction. It is the inverse companion of the team's repeated-addition multiplier. Operands arrive serially on a shared `data_in` bus, dividend first and then divisor, following a `start` pulse. A controller FSM with a subtract/compare datapath produces `quot`/`rem` and raises `done`. It sits beside the multiplier in the arithmetic datapath and uses the same start/load/done handshake style.

## Interface
- `WIDTH`, default 16: operand, quotient and remainder width.
- `clk`  input  1  rising-edge clock; the only clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `start`  input  1  begin a division; sampled only in IDLE and DONE.
- `data_in`  input  WIDTH  operand bus; dividend in LDA, divisor in LDB.
- `quot`  output  WIDTH  quotient, registered.
- `rem`  output  WIDTH  remainder, registered.
- `done`  output  1  result valid; high exactly while in DONE.
- `busy`  output  1  high in LDA, LDB, CHECK, SUB.
- `div0`  output  1  divisor was zero; valid with `done`.

## Operation
- States: IDLE, LDA, LDB, CHECK, SUB, DONE.
- IDLE, `start`=1 → LDA; otherwise stay in IDLE.
- LDA: `rem` <= `data_in`, `quot` <= 0, `div0` <= 0 → LDB.
- LDB: divisor register <= `data_in` → CHECK.
- CHECK, divisor == 0: `div0` <= 1 → DONE. `quot` stays 0 and `rem` keeps the dividend.
- CHECK, divisor != 0 → SUB.
- SUB, `rem` >= divisor: `rem` <= `rem` − divisor, `quot` <= `quot` + 1; stay in SUB.
- SUB, `rem` < divisor → DONE; no register update.
- DONE: `quot`, `rem` and `div0` hold. `start`=1 → LDA, a back-to-back restart. Otherwise stay in DONE.
- Arithmetic is unsigned and WIDTH bits.
  - Subtraction happens only when `rem` >= divisor, so it never underflows.
  - The quotient cannot exceed 2^WIDTH−1, so it never wraps.
- `start` in LDA, LDB, CHECK or SUB is ignored.
- Outputs are Moore outputs: `done` = (state == DONE); `busy` = state in {LDA, LDB, CHECK, SUB}.

## Timing
- Reset (`rst_n` low, at any time including mid-division): state = IDLE, `quot` = 0, `rem` = 0, divisor = 0, `done` = 0, `busy` = 0, `div0` = 0. This takes effect immediately and asynchronously, and any in-progress division is discarded.
- Edge numbering: e0 is the edge that samples `start`=1 in IDLE or DONE.
- Dividend is sampled on e1; divisor is sampled on e2.
- CHECK is evaluated on e3.
- For quotient Q, the subtractions occur on e4 … e(3+Q).
- DONE is entered on e(4+Q), with `done` high from that edge onward.
- Divide by zero: DONE is entered on e3.
- Worst case (WIDTH=16, dividend 65535, divisor 1): `done` at e65539.
- `done` falls on the edge after a restart `start` is sampled (entry to LDA).

## Configuration
- Macro `DIV_REM_OUT_EN`.
- Defined: `rem` outputs the remainder register as specified above.
- Undefined:
  - The `rem` port remains but is driven constant 0.
  - The internal working register still exists, since it is needed for the compare, so `quot`, `done` and `div0` behaviour and all timing are unchanged.

## Structure
- Shared package `div_repsub_pkg`:
  - state enum with IDLE, LDA, LDB, CHECK, SUB, DONE, encoded 3'd0–3'd5;
  - default-width localparam (16).
- One sub-module, `div_repsub_dp`, is the datapath:
  - working-remainder register, divisor register, quotient counter;
  - `rem` >= divisor comparator and divisor-zero detect.
  - It exports `ge` and `dz` flags to the FSM, and takes `ld_rem`, `ld_div`, `clr_q` and `sub` controls from it.

## Test plan
- 17 / 5: `start` at e0, `data_in` = 17 at e1, 5 at e2 → `done` at e7, `quot` = 3, `rem` = 2, `div0` = 0.
- 3 / 7 → `done` at e4, `quot` = 0, `rem` = 3. Also 20 / 5 → `done` at e8, `quot` = 4, `rem` = 0.
- 42 / 0 → `done` at e3, `div0` = 1, `quot` = 0, `rem` = 42. The next division, 9 / 3, must show `div0` = 0, `quot` = 3, `rem` = 0.
- 65535 / 1 → `done` at e65539, `quot` = 65535, `rem` = 0. Check `busy` is high e1 through e65538.
- Pulse `start` during SUB of 100 / 3: it is ignored and the result is `quot` = 33, `rem` = 1. Assert `rst_n` low mid-SUB: all outputs are 0 immediately, and after release the FSM sits in IDLE until the next `start`.
- With `DIV_REM_OUT_EN` undefined, 17 / 5 → `quot` = 3, `rem` = 0, and `done` is still at e7.

Source files
------------

// File: rtl/div_repsub_pkg.sv
// Shared types for the repeated-subtraction divider: FSM state encoding and default width.
package div_repsub_pkg;

    localparam int DIV_DEF_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LDA   = 3'd1,
        ST_LDB   = 3'd2,
        ST_CHECK = 3'd3,
        ST_SUB   = 3'd4,
        ST_DONE  = 3'd5
    } div_state_e;

endpackage

// File: rtl/div_repsub_dp.sv
// Divider datapath: working remainder, divisor and quotient counter, plus the
// rem >= divisor compare and divisor-zero detect consumed by the controller.
module div_repsub_dp
    import div_repsub_pkg::*;
#(
    parameter int WIDTH = DIV_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_rem,
    input  logic             ld_div,
    input  logic             clr_q,
    input  logic             sub,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             ge,
    output logic             dz
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_quot;

    // Working remainder: loaded with the dividend, reduced by the divisor on each subtract.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
        end else if (ld_rem) begin
            r_rem <= data_in;
        end else if (sub) begin
            r_rem <= r_rem - r_div;
        end else begin
            r_rem <= r_rem;
        end
    end

    // Divisor register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (ld_div) begin
            r_div <= data_in;
        end else begin
            r_div <= r_div;
        end
    end

    // Quotient counter; only incremented alongside a non-underflowing subtract, so it cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quot <= '0;
        end else if (clr_q) begin
            r_quot <= '0;
        end else if (sub) begin
            r_quot <= r_quot + ONE;
        end else begin
            r_quot <= r_quot;
        end
    end

    assign ge   = (r_rem >= r_div);
    assign dz   = (r_div == '0);
    assign quot = r_quot;
    assign rem  = r_rem;

endmodule

// File: rtl/div_repsub.sv
// Sequential unsigned divider by repeated subtraction with serial operand load.
// Build macro DIV_REM_OUT_EN: when defined, rem reports the remainder; otherwise rem is tied to 0.
module div_repsub
    import div_repsub_pkg::*;
#(
    parameter int WIDTH = DIV_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             done,
    output logic             busy,
    output logic             div0
);

    div_state_e       r_state;
    logic             r_done;
    logic             r_busy;
    logic             r_div0;
    logic             w_ld_rem;
    logic             w_ld_div;
    logic             w_clr_q;
    logic             w_sub;
    logic             w_ge;
    logic             w_dz;
    logic [WIDTH-1:0] w_rem;

    div_repsub_dp #(.WIDTH(WIDTH)) u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld_rem  (w_ld_rem),
        .ld_div  (w_ld_div),
        .clr_q   (w_clr_q),
        .sub     (w_sub),
        .data_in (data_in),
        .quot    (quot),
        .rem     (w_rem),
        .ge      (w_ge),
        .dz      (w_dz)
    );

    // Datapath strobes decoded from the current state.
    always_comb begin
        w_ld_rem = 1'b0;
        w_ld_div = 1'b0;
        w_clr_q  = 1'b0;
        w_sub    = 1'b0;
        case (r_state)
            ST_LDA: begin
                w_ld_rem = 1'b1;
                w_clr_q  = 1'b1;
            end
            ST_LDB:  w_ld_div = 1'b1;
            ST_SUB:  w_sub    = w_ge;
            default: w_sub    = 1'b0;
        endcase
    end

    // Controller; done/busy are registered so they track the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LDA;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LDA: begin
                    r_div0  <= 1'b0;
                    r_state <= ST_LDB;
                end
                ST_LDB: begin
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (w_dz) begin
                        r_div0  <= 1'b1;
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    if (!w_ge) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        r_state <= ST_LDA;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_div0  <= 1'b0;
                end
            endcase
        end
    end

    assign done = r_done;
    assign busy = r_busy;
    assign div0 = r_div0;

`ifdef DIV_REM_OUT_EN
    assign rem = w_rem;
`else
    // The working remainder still drives the compare; only the port is silenced.
    logic w_unused_rem;
    assign w_unused_rem = ^w_rem;
    assign rem = '0;
`endif

endmodule

// File: tb/tb_div_repsub.sv
// Table-driven self-checking bench for div_repsub, plus hand sequences for
// start-during-SUB and asynchronous reset mid-division.
module tb_div_repsub;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         done;
    logic         busy;
    logic         div0;

    int checks = 0;
    int errors = 0;

    div_repsub #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .quot    (quot),
        .rem     (rem),
        .done    (done),
        .busy    (busy),
        .div0    (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rem_exp(input logic [W-1:0] r);
`ifdef DIV_REM_OUT_EN
        return r;
`else
        return r & 16'h0000;
`endif
    endfunction

    // Runs one division. Edge k=0 samples start; pulse_k>0 re-pulses start for one cycle.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int pulse_k,
                           output int lat, output logic busy_ok);
        int k;
        @(negedge clk);
        start = 1'b1;
        k = 0;
        lat = -1;
        busy_ok = 1'b1;
        while (k < 70000 && lat < 0) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                start   = 1'b0;
                data_in = a;
            end else if (k == 1) begin
                data_in = b;
            end
            if (pulse_k > 0 && k == pulse_k) start = 1'b1;
            if (pulse_k > 0 && k == pulse_k + 1) start = 1'b0;
            if (done) lat = k;
            else if (!busy) busy_ok = 1'b0;
            k++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int pulse_k);
        int   lat;
        logic bok;
        run_div(v.a, v.b, pulse_k, lat, bok);
        check($sformatf("latency %0d/%0d", v.a, v.b), lat, v.lat);
        check($sformatf("busy_while_running %0d/%0d", v.a, v.b), {31'd0, bok}, 32'd1);
        check($sformatf("busy_at_done %0d/%0d", v.a, v.b), {31'd0, busy}, 32'd0);
        check($sformatf("quot %0d/%0d", v.a, v.b), quot, v.q);
        check($sformatf("rem %0d/%0d", v.a, v.b), rem, rem_exp(v.r));
        check($sformatf("div0 %0d/%0d", v.a, v.b), {31'd0, div0}, {31'd0, v.z});
        // DONE must hold its results while start stays low.
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("hold %0d/%0d", v.a, v.b), {31'd0, done}, 32'd1);
        check($sformatf("hold_quot %0d/%0d", v.a, v.b), quot, v.q);
    endtask

    vec_t vecs[8];

    initial begin
        vec_t v;
        vecs[0] = '{a: 16'd17,    b: 16'd5, q: 16'd3,     r: 16'd2,  z: 1'b0, lat: 7};
        vecs[1] = '{a: 16'd3,     b: 16'd7, q: 16'd0,     r: 16'd3,  z: 1'b0, lat: 4};
        vecs[2] = '{a: 16'd20,    b: 16'd5, q: 16'd4,     r: 16'd0,  z: 1'b0, lat: 8};
        vecs[3] = '{a: 16'd42,    b: 16'd0, q: 16'd0,     r: 16'd42, z: 1'b1, lat: 3};
        vecs[4] = '{a: 16'd9,     b: 16'd3, q: 16'd3,     r: 16'd0,  z: 1'b0, lat: 7};
        vecs[5] = '{a: 16'd5,     b: 16'd5, q: 16'd1,     r: 16'd0,  z: 1'b0, lat: 5};
        vecs[6] = '{a: 16'd0,     b: 16'd9, q: 16'd0,     r: 16'd0,  z: 1'b0, lat: 4};
        vecs[7] = '{a: 16'd65535, b: 16'd1, q: 16'd65535, r: 16'd0,  z: 1'b0, lat: 65539};

        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_quot", quot, 32'd0);
        check("reset_rem",  rem,  32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_div0", {31'd0, div0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], 0);

        // Start pulsed during SUB is ignored.
        v = '{a: 16'd100, b: 16'd3, q: 16'd33, r: 16'd1, z: 1'b0, lat: 37};
        run_vec(v, 10);

        // Async reset in the middle of SUB.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0; data_in = 16'd100;
        @(posedge clk); #1; data_in = 16'd3;
        repeat (10) @(posedge clk);
        #1;
        check("midsub_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_quot", quot, 32'd0);
        check("async_rst_rem",  rem,  32'd0);
        check("async_rst_done", {31'd0, done}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_div0", {31'd0, div0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_after_rst_busy", {31'd0, busy}, 32'd0);
        check("idle_after_rst_done", {31'd0, done}, 32'd0);
        run_vec(vecs[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
